node_detect: RTL and testbench
==============================

# node_detect

Upstream stage of the turn controller: watches the three centre line-sensor ADC channels and raises `node` when the bot crosses a junction (all three sensors on black). It holds `node` until the turn controller acknowledges with `node_r`, then blanks detection for a fixed time so the same junction is not counted twice. It also flags a lost line.

## Interface
- `BLACK_TH`, 1280: channel value above this sets that channel's black flag.
- `WHITE_TH`, 768: channel value below this clears the black flag; values in between hold the flag (hysteresis).
- `CONFIRM_N`, 4: consecutive all-black samples required to assert `node`. Range 1..15.
- `LOST_N`, 8: consecutive all-white samples required to assert `line_lost`. Range 1..15.
- `BLANK_CYCLES`, 25000000: clock cycles of re-detection blanking after acknowledge. Counter is 25 bits.
- `TIMEOUT_CYCLES`, 100000000: only used with `NODE_TIMEOUT_EN`. Counter is 27 bits.
- `clk_50` input 1: 50 MHz system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `ch5`, `ch6`, `ch7` input 12 each: ADC results for left, centre and right sensors.
- `sample_valid` input 1: one-cycle strobe; the `ch*` values are new and valid on this cycle.
- `node_r` input 1: turn-complete acknowledge from the turn controller.
- `node` output 1: junction present; a level signal.
- `blk` output 3: registered black flags {ch7, ch6, ch5}.
- `line_lost` output 1: all sensors white for `LOST_N` samples.
- `fault` output 1: sticky acknowledge-timeout flag; tied 0 when the macro is absent.

## Operation
- Black flags update only on `sample_valid`, per channel:
  - `ch > BLACK_TH` sets the flag.
  - `ch < WHITE_TH` clears the flag.
  - Otherwise the flag holds.
  - The qualify, confirm and lost logic reads the updated flags in the same cycle.
- `allb` = all three flags set; `allw` = all three flags clear.
- State machine:
  - IDLE: on `sample_valid` with `allb`, set the confirm count to 1. If `CONFIRM_N`==1, go to NODE; otherwise go to CONFIRM.
  - CONFIRM: on `sample_valid` with `allb`, increment the count; when the count reaches `CONFIRM_N`, go to NODE. On `sample_valid` without `allb`, clear the count and return to IDLE. Cycles without `sample_valid` leave state and count unchanged.
  - NODE: `node`=1. When `node_r`=1, go to RELEASE and load the blank counter with 0.
  - RELEASE: `node`=0. The blank counter increments every cycle; at `BLANK_CYCLES`-1 return to IDLE. Flags keep updating, but no confirm counting happens here.
- Leaving RELEASE with the line still all-black requires `CONFIRM_N` fresh samples before `node` can rise again.
- `node_r` is ignored in IDLE, CONFIRM and RELEASE.
- `line_lost`:
  - The lost counter increments on each `sample_valid` with `allw` and saturates at `LOST_N`.
  - Any `sample_valid` without `allw` clears it.
  - `line_lost` = (lost counter == `LOST_N`).
  - It runs in all states. It is forced 0 and its counter cleared while in NODE.

## Timing
- Reset (async assert, sync release): state IDLE, all counters 0, `blk`=000, `node`=0, `line_lost`=0, `fault`=0.
- Reset mid-operation, including in NODE, drops `node` immediately.
- `node` rises on the clock edge that samples the `CONFIRM_N`-th qualifying `sample_valid`. It is visible the following cycle, i.e. 1-cycle latency from the strobe.
- `node` falls on the edge where NODE samples `node_r`=1. The turn controller sees `node`=0 one cycle after it raised `node_r`.
- A `sample_valid` arriving in the same cycle as the NODE to RELEASE transition updates the flags only.
- `blk` updates on the edge that samples `sample_valid`.
- `line_lost` has the same 1-cycle latency as `blk`.

## Configuration
- `NODE_TIMEOUT_EN` defined:
  - A 27-bit counter runs while in NODE.
  - At `TIMEOUT_CYCLES`-1 without `node_r`, the block forces the transition to RELEASE exactly as an acknowledge would, and sets `fault`.
  - `fault` clears only on reset.
- `NODE_TIMEOUT_EN` undefined: NODE waits indefinitely, `fault` is constant 0, and no timeout counter is built.

## Test plan
- Confirm: reset, then 4 strobes with ch5/6/7=1500 → `node` goes 1 the cycle after the 4th strobe and `blk`=111. With only 3 strobes, `node` stays 0.
- Confirm abort: 3 strobes all-black, 1 strobe with ch6=500, then 3 strobes all-black → `node` stays 0. A 4th all-black strobe then raises `node`.
- Hysteresis: ch5 goes 1500 → 1000 → 700 → `blk[0]` reads 1, 1, 0. The pattern 700 → 1000 gives 0, 0.
- Acknowledge and blanking (`BLANK_CYCLES`=100 in the bench): `node`=1, then pulse `node_r` → `node`=0 next cycle. Continuous all-black strobes during the 100 blank cycles → no `node`. After blanking, `node` reasserts after 4 strobes.
- Lost line: 8 strobes with all channels at 200 → `line_lost`=1 after the 8th. One strobe at ch6=1500 → `line_lost`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=50 in the bench): reach NODE with no `node_r` → after 50 cycles, `node`=0 and `fault`=1, and both stay so after blanking. Asserting `rst_n`=0 clears `fault`.

Source files
------------

// File: rtl/node_detect_if.sv
// ---------------------------------------------------------------------------
// node_detect_if
//
// Purpose : bundles the sensor sample bus, the turn-controller handshake and
//           the status outputs of node_detect into one interface.
//
// Signals :
//   ch5, ch6, ch7  [11:0]  ADC results for left, centre and right sensors
//   sample_valid           one-cycle strobe, ch* are new on this cycle
//   node_r                 turn-complete acknowledge from the turn controller
//   node                   junction present (level)
//   blk            [2:0]   registered black flags {ch7, ch6, ch5}
//   line_lost              all sensors white for a run of samples
//   fault                  sticky acknowledge-timeout flag
//
// Modports:
//   master : the side that supplies samples and acknowledges (turn controller)
//   slave  : node_detect itself
// ---------------------------------------------------------------------------
interface node_detect_if;

   logic [11:0] ch5;
   logic [11:0] ch6;
   logic [11:0] ch7;
   logic        sample_valid;
   logic        node_r;
   logic        node;
   logic [2:0]  blk;
   logic        line_lost;
   logic        fault;

   // The sample source and turn controller drive the inputs and watch status.
   modport master (
      output ch5, ch6, ch7, sample_valid, node_r,
      input  node, blk, line_lost, fault
   );

   // The detector consumes samples and produces status.
   modport slave (
      input  ch5, ch6, ch7, sample_valid, node_r,
      output node, blk, line_lost, fault
   );

endinterface

// File: rtl/node_detect.sv
// ---------------------------------------------------------------------------
// node_detect
//
// Purpose : watches the three centre line-sensor ADC channels and raises
//           node when the bot crosses a junction (all three sensors black
//           for CONFIRM_N consecutive samples). node is held until the turn
//           controller acknowledges with node_r, after which detection is
//           blanked for BLANK_CYCLES clocks so the same junction is not
//           counted twice. A separate counter flags a lost line when all
//           sensors read white for LOST_N consecutive samples.
//
// Ports   :
//   clk_50  input   50 MHz system clock
//   rst_n   input   asynchronous active-low reset (release synchronised
//                   upstream)
//   bus     slave   node_detect_if: ch5/ch6/ch7, sample_valid, node_r in;
//                   node, blk, line_lost, fault out
//
// Parameters:
//   BLACK_TH        channel value above this sets its black flag
//   WHITE_TH        channel value below this clears its black flag
//   CONFIRM_N       all-black samples needed to raise node (1..15)
//   LOST_N          all-white samples needed to raise line_lost (1..15)
//   BLANK_CYCLES    re-detection blanking after acknowledge (25-bit counter)
//   TIMEOUT_CYCLES  acknowledge timeout (27-bit counter), only present when
//                   NODE_TIMEOUT_EN is defined
//
// Build option:
//   NODE_TIMEOUT_EN  when defined, NODE gives up waiting for node_r after
//                    TIMEOUT_CYCLES, releases on its own and sets the sticky
//                    fault flag. When undefined, NODE waits indefinitely,
//                    fault is tied 0 and no timeout counter exists.
// ---------------------------------------------------------------------------
module node_detect #(
   parameter int BLACK_TH       = 1280,
   parameter int WHITE_TH       = 768,
   parameter int CONFIRM_N      = 4,
   parameter int LOST_N         = 8,
   parameter int BLANK_CYCLES   = 25000000
`ifdef NODE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 100000000
`endif
) (
   input logic          clk_50,
   input logic          rst_n,
   node_detect_if.slave bus
);

   // Parameters recast to the widths of the values they are compared with.
   localparam logic [11:0] BLACK_LVL   = 12'(BLACK_TH);
   localparam logic [11:0] WHITE_LVL   = 12'(WHITE_TH);
   localparam logic [3:0]  CONFIRM_LVL = 4'(CONFIRM_N);
   localparam logic [3:0]  LOST_LVL    = 4'(LOST_N);
   localparam logic [24:0] BLANK_LAST  = 25'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM,
      NODE,
      RELEASE
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  blk_q;
   logic [2:0]  blk_d;
   logic [3:0]  confirmCnt_q;
   logic [3:0]  confirmCnt_d;
   logic [24:0] blankCnt_q;
   logic [24:0] blankCnt_d;
   logic [3:0]  lostCnt_q;
   logic [3:0]  lostCnt_d;
   logic        sampleBlack;
   logic        sampleWhite;
   logic        timeoutHit;

   // Hysteresis for one channel: above the black threshold sets the flag,
   // below the white threshold clears it, anything in between keeps the
   // previous reading so a sensor sitting on the line edge does not chatter.
   function automatic logic flagNext(input logic [11:0] ch, input logic cur);
      logic nxt;
      nxt = cur;
      if (ch > BLACK_LVL) begin
         nxt = 1'b1;
      end else if (ch < WHITE_LVL) begin
         nxt = 1'b0;
      end
      return nxt;
   endfunction

   // Next black flags. They only move on a sample strobe; the rest of the
   // block looks at these updated flags so a strobe is judged on its own
   // data rather than on the previous sample's.
   always_comb begin
      blk_d = blk_q;
      if (bus.sample_valid) begin
         blk_d[0] = flagNext(bus.ch5, blk_q[0]);
         blk_d[1] = flagNext(bus.ch6, blk_q[1]);
         blk_d[2] = flagNext(bus.ch7, blk_q[2]);
      end
   end

   // Qualified sample events: a strobe whose updated flags are all black or
   // all white. Both are 0 on cycles without a strobe.
   assign sampleBlack = bus.sample_valid & (&blk_d);
   assign sampleWhite = bus.sample_valid & ~(|blk_d);

`ifdef NODE_TIMEOUT_EN
   localparam logic [26:0] TIMEOUT_LAST = 27'(TIMEOUT_CYCLES - 1);

   logic [26:0] timeoutCnt_q;
   logic [26:0] timeoutCnt_d;
   logic        fault_q;
   logic        fault_d;

   // The timeout only fires when the acknowledge has not arrived on the very
   // cycle the counter expires; a real acknowledge always takes priority so
   // fault is never set for a controller that answered just in time.
   assign timeoutHit = (state_q == NODE) && !bus.node_r &&
                       (timeoutCnt_q == TIMEOUT_LAST);

   // The timeout counter runs only while node is being held and restarts
   // from zero for each junction. fault is sticky until reset.
   always_comb begin
      timeoutCnt_d = '0;
      fault_d      = fault_q | timeoutHit;
      if ((state_q == NODE) && !bus.node_r && !timeoutHit) begin
         timeoutCnt_d = timeoutCnt_q + 27'd1;
      end
   end

   // Timeout counter and fault register.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         timeoutCnt_q <= '0;
         fault_q      <= 1'b0;
      end else begin
         timeoutCnt_q <= timeoutCnt_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.fault = fault_q;
`else
   assign timeoutHit = 1'b0;
   assign bus.fault  = 1'b0;
`endif

   // Junction state machine. IDLE and CONFIRM count consecutive all-black
   // strobes; any non-black strobe throws the partial count away. NODE holds
   // the junction until it is acknowledged (or times out). RELEASE is a
   // plain delay during which no confirm counting happens, so a line that
   // is still all-black afterwards needs a full fresh run of CONFIRM_N
   // samples before node can rise again.
   always_comb begin
      state_d      = state_q;
      confirmCnt_d = confirmCnt_q;
      blankCnt_d   = blankCnt_q;
      case (state_q)
         IDLE: begin
            if (sampleBlack) begin
               if (CONFIRM_LVL == 4'd1) begin
                  state_d      = NODE;
                  confirmCnt_d = '0;
               end else begin
                  state_d      = CONFIRM;
                  confirmCnt_d = 4'd1;
               end
            end
         end
         CONFIRM: begin
            if (sampleBlack) begin
               if ((confirmCnt_q + 4'd1) == CONFIRM_LVL) begin
                  state_d      = NODE;
                  confirmCnt_d = '0;
               end else begin
                  confirmCnt_d = confirmCnt_q + 4'd1;
               end
            end else if (bus.sample_valid) begin
               state_d      = IDLE;
               confirmCnt_d = '0;
            end
         end
         NODE: begin
            if (bus.node_r || timeoutHit) begin
               state_d    = RELEASE;
               blankCnt_d = '0;
            end
         end
         RELEASE: begin
            if (blankCnt_q == BLANK_LAST) begin
               state_d    = IDLE;
               blankCnt_d = '0;
            end else begin
               blankCnt_d = blankCnt_q + 25'd1;
            end
         end
         default: begin
            state_d      = IDLE;
            confirmCnt_d = '0;
            blankCnt_d   = '0;
         end
      endcase
   end

   // Lost-line run length. It saturates at LOST_N so line_lost stays up
   // for as long as the line stays white, and it is held at zero while a
   // junction is being reported since the bot is by definition on the line.
   always_comb begin
      lostCnt_d = lostCnt_q;
      if (state_q == NODE) begin
         lostCnt_d = '0;
      end else if (bus.sample_valid) begin
         if (sampleWhite) begin
            if (lostCnt_q != LOST_LVL) begin
               lostCnt_d = lostCnt_q + 4'd1;
            end
         end else begin
            lostCnt_d = '0;
         end
      end
   end

   // State, flag and counter registers. Reset drops node at once because
   // node is decoded straight from the state register.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         blk_q        <= '0;
         confirmCnt_q <= '0;
         blankCnt_q   <= '0;
         lostCnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         confirmCnt_q <= confirmCnt_d;
         blankCnt_q   <= blankCnt_d;
         lostCnt_q    <= lostCnt_d;
      end
   end

   // Status outputs, all decoded from registers.
   assign bus.node      = (state_q == NODE);
   assign bus.blk       = blk_q;
   assign bus.line_lost = (state_q != NODE) && (lostCnt_q == LOST_LVL);

endmodule

// File: tb/tb_node_detect.sv
// ---------------------------------------------------------------------------
// tb_node_detect
//
// Purpose : self-checking bench for node_detect. A behavioural model tracks
//           flags, black/white run lengths, a hold flag and a blanking
//           countdown; a compare process checks every output against it on
//           every falling edge, and directed scenarios pin both the DUT and
//           the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_node_detect;

   localparam int BLACK_TH       = 1280;
   localparam int WHITE_TH       = 768;
   localparam int CONFIRM_N      = 4;
   localparam int LOST_N         = 8;
   localparam int BLANK_CYCLES   = 100;
   localparam int TIMEOUT_CYCLES = 50;
`ifdef NODE_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic clk_50   = 1'b0;
   logic rst_n    = 1'b1;
   bit   checking = 1'b0;
   int   assertCount = 0;
   int   failCount   = 0;

   node_detect_if bus ();

   node_detect #(
      .BLACK_TH       (BLACK_TH),
      .WHITE_TH       (WHITE_TH),
      .CONFIRM_N      (CONFIRM_N),
      .LOST_N         (LOST_N),
      .BLANK_CYCLES   (BLANK_CYCLES)
`ifdef NODE_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
   ) dut (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   // 50 MHz clock, 20 ns period.
   always #10 clk_50 = ~clk_50;

   // Model state: what the detector should know after each clock edge,
   // expressed as run lengths and countdowns rather than states.
   typedef struct {
      logic [2:0] flags;
      int         blackRun;
      bit         nodeUp;
      int         blankLeft;
      int         lostRun;
      int         nodeAge;
      bit         fault;
   } model_t;

   model_t mdl;

   // One clock edge of the model.
   function automatic model_t modelStep(input model_t m, input logic [11:0] c5,
                                        input logic [11:0] c6, input logic [11:0] c7,
                                        input logic sv, input logic nr);
      model_t      r;
      logic [11:0] chv [3];
      bit          allBlack;
      bit          allWhite;
      r = m;
      chv[0] = c5;
      chv[1] = c6;
      chv[2] = c7;
      if (sv) begin
         for (int i = 0; i < 3; i++) begin
            if (int'(chv[i]) > BLACK_TH) r.flags[i] = 1'b1;
            else if (int'(chv[i]) < WHITE_TH) r.flags[i] = 1'b0;
         end
      end
      allBlack = (r.flags == 3'b111);
      allWhite = (r.flags == 3'b000);
      if (m.nodeUp) begin
         r.lostRun = 0;
         if (nr) begin
            r.nodeUp    = 1'b0;
            r.blankLeft = BLANK_CYCLES;
         end else if (TIMEOUT_ON && (m.nodeAge == TIMEOUT_CYCLES - 1)) begin
            r.nodeUp    = 1'b0;
            r.blankLeft = BLANK_CYCLES;
            r.fault     = 1'b1;
         end else begin
            r.nodeAge = m.nodeAge + 1;
         end
      end else begin
         if (sv) r.lostRun = allWhite ? ((m.lostRun < LOST_N) ? m.lostRun + 1 : LOST_N) : 0;
         if (m.blankLeft > 0) begin
            r.blankLeft = m.blankLeft - 1;
            r.blackRun  = 0;
         end else if (sv) begin
            r.blackRun = allBlack ? m.blackRun + 1 : 0;
            if (r.blackRun == CONFIRM_N) begin
               r.nodeUp   = 1'b1;
               r.blackRun = 0;
               r.nodeAge  = 0;
            end
         end
      end
      return r;
   endfunction

   // Advance the model on the same edges the DUT sees.
   always @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         mdl <= '{flags: 3'b000, blackRun: 0, nodeUp: 1'b0, blankLeft: 0,
                  lostRun: 0, nodeAge: 0, fault: 1'b0};
      end else begin
         mdl <= modelStep(mdl, bus.ch5, bus.ch6, bus.ch7, bus.sample_valid, bus.node_r);
      end
   end

   // Compare one value; the single place that counts and reports.
   task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
      assertCount++;
      if (got !== want) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
      end
   endtask

   // Pin a DUT output and the matching model value to a hand-computed literal.
   task automatic checkLiteral(input string name, input logic [3:0] dutVal,
                               input logic [3:0] mdlVal, input logic [3:0] want);
      checkOutput(name, dutVal, want);
      checkOutput({name, " (model)"}, mdlVal, want);
   endtask

   // Every falling edge: all outputs against the model.
   always @(negedge clk_50) begin
      if (checking) begin
         checkOutput("node", {3'b0, bus.node}, {3'b0, mdl.nodeUp});
         checkOutput("blk", {1'b0, bus.blk}, {1'b0, mdl.flags});
         checkOutput("line_lost", {3'b0, bus.line_lost},
                     {3'b0, (!mdl.nodeUp && mdl.lostRun == LOST_N)});
         checkOutput("fault", {3'b0, bus.fault}, {3'b0, mdl.fault});
      end
   end

   // Drive one cycle of inputs, let the next rising edge sample them and
   // return just after it so the resulting outputs can be read.
   task automatic applyStimulus(input int c5, input int c6, input int c7,
                                input logic sv, input logic nr);
      bus.ch5          = 12'(c5);
      bus.ch6          = 12'(c6);
      bus.ch7          = 12'(c7);
      bus.sample_valid = sv;
      bus.node_r       = nr;
      @(posedge clk_50);
      #1;
   endtask

   task automatic strobe(input int v);
      applyStimulus(v, v, v, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic ack();
      applyStimulus(0, 0, 0, 1'b0, 1'b1);
   endtask

   // Directed scenarios.
   initial begin
      bus.ch5          = '0;
      bus.ch6          = '0;
      bus.ch7          = '0;
      bus.sample_valid = 1'b0;
      bus.node_r       = 1'b0;

      // Reset state.
      #1 rst_n = 1'b0;
      #1 checking = 1'b1;
      checkLiteral("reset node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      checkLiteral("reset blk", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'd0);
      checkLiteral("reset line_lost", {3'b0, bus.line_lost}, 4'd0, 4'd0);
      checkLiteral("reset fault", {3'b0, bus.fault}, {3'b0, mdl.fault}, 4'd0);
      @(negedge clk_50);
      @(negedge clk_50);
      rst_n = 1'b1;
      @(posedge clk_50);
      #1;

      // Confirm: three all-black strobes are not enough, the fourth is.
      $display("[TB] confirm");
      strobe(1500);
      checkLiteral("confirm blk", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0111);
      strobe(1500);
      strobe(1500);
      checkLiteral("confirm 3 strobes", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      strobe(1500);
      checkLiteral("confirm 4 strobes", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);

      // Acknowledge, then blanking with the line still all-black.
      $display("[TB] acknowledge and blanking");
      ack();
      checkLiteral("ack drops node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      for (int i = 0; i < BLANK_CYCLES; i++) strobe(1500);
      checkLiteral("blank end node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      strobe(1500);
      strobe(1500);
      strobe(1500);
      checkLiteral("post-blank 3 strobes", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      strobe(1500);
      checkLiteral("post-blank 4 strobes", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);
      ack();
      idle(BLANK_CYCLES);
      applyStimulus(0, 0, 0, 1'b0, 1'b1);
      checkLiteral("node_r ignored in idle", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);

      // Confirm abort by one non-black strobe.
      $display("[TB] confirm abort");
      strobe(1500);
      strobe(1500);
      strobe(1500);
      applyStimulus(1500, 500, 1500, 1'b1, 1'b0);
      checkLiteral("abort blk", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0101);
      strobe(1500);
      strobe(1500);
      strobe(1500);
      checkLiteral("abort 3 after break", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      strobe(1500);
      checkLiteral("abort 4 after break", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);
      // Strobe on the acknowledge cycle only updates flags.
      applyStimulus(200, 1500, 1500, 1'b1, 1'b1);
      checkLiteral("ack+strobe node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      checkLiteral("ack+strobe blk", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0110);
      idle(BLANK_CYCLES);

      // Hysteresis on ch5 with ch6/ch7 held in the dead band.
      $display("[TB] hysteresis");
      applyStimulus(1500, 1000, 1000, 1'b1, 1'b0);
      checkLiteral("hyst 1500", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0111);
      applyStimulus(1000, 1000, 1000, 1'b1, 1'b0);
      checkLiteral("hyst 1000 hold", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0111);
      applyStimulus(700, 1000, 1000, 1'b1, 1'b0);
      checkLiteral("hyst 700", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0110);
      applyStimulus(700, 1000, 1000, 1'b1, 1'b0);
      applyStimulus(1000, 1000, 1000, 1'b1, 1'b0);
      checkLiteral("hyst 700->1000", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0110);
      checkLiteral("hyst no node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);

      // Lost line.
      $display("[TB] lost line");
      for (int i = 0; i < LOST_N - 1; i++) strobe(200);
      checkLiteral("lost after 7", {3'b0, bus.line_lost}, 4'd0, 4'd0);
      strobe(200);
      checkLiteral("lost after 8", {3'b0, bus.line_lost}, {3'b0, mdl.lostRun == LOST_N}, 4'd1);
      idle(1);
      strobe(200);
      checkLiteral("lost saturates", {3'b0, bus.line_lost}, {3'b0, mdl.lostRun == LOST_N}, 4'd1);
      applyStimulus(200, 1500, 200, 1'b1, 1'b0);
      checkLiteral("lost cleared", {3'b0, bus.line_lost}, {3'b0, mdl.lostRun == LOST_N}, 4'd0);

      // Holding node with no acknowledge.
      $display("[TB] acknowledge timeout");
      for (int i = 0; i < CONFIRM_N; i++) strobe(1500);
      checkLiteral("hold node up", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);
`ifdef NODE_TIMEOUT_EN
      idle(TIMEOUT_CYCLES - 1);
      checkLiteral("timeout not yet", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);
      idle(1);
      checkLiteral("timeout node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      checkLiteral("timeout fault", {3'b0, bus.fault}, {3'b0, mdl.fault}, 4'd1);
      idle(BLANK_CYCLES);
      checkLiteral("fault sticky", {3'b0, bus.fault}, {3'b0, mdl.fault}, 4'd1);
      checkLiteral("node stays low", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
`else
      idle(TIMEOUT_CYCLES + 10);
      checkLiteral("no timeout node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);
      checkLiteral("no timeout fault", {3'b0, bus.fault}, {3'b0, mdl.fault}, 4'd0);
      ack();
      idle(BLANK_CYCLES);
`endif

      // Reset while holding node.
      $display("[TB] reset in node");
      for (int i = 0; i < CONFIRM_N; i++) strobe(1500);
      checkLiteral("pre-reset node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd1);
      rst_n = 1'b0;
      #1;
      checkLiteral("reset drops node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      checkLiteral("reset clears fault", {3'b0, bus.fault}, {3'b0, mdl.fault}, 4'd0);
      checkLiteral("reset clears blk", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'd0);
      @(negedge clk_50);
      rst_n = 1'b1;
      @(posedge clk_50);
      #1;
      strobe(1500);
      checkLiteral("after reset blk", {1'b0, bus.blk}, {1'b0, mdl.flags}, 4'b0111);
      checkLiteral("after reset node", {3'b0, bus.node}, {3'b0, mdl.nodeUp}, 4'd0);
      idle(2);

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
